// File: rtl/imem_prefetch_pkg.sv
// Shared types and helpers for the sequential instruction prefetch buffer.
package imem_prefetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pf_state_e;

    typedef struct packed {
        logic [XLEN-1:0] tag;
        logic [XLEN-1:0] data;
    } pf_entry_t;

    // Widened to 33 bits so a region ending at the top of memory cannot wrap.
    function automatic logic in_region(input logic [XLEN-1:0] addr,
                                       input logic [XLEN-1:0] base,
                                       input logic [XLEN:0]   size);
        logic [XLEN:0] a;
        logic [XLEN:0] lo;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        return (a >= lo) && (a < lo + size);
    endfunction

endpackage

// File: rtl/imem_prefetch_fifo.sv
// Prefetch FIFO of tagged instruction words with flush and a combinational head.
module pf_fifo
    import imem_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  pf_entry_t                push_entry,
    output pf_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    pf_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: storage is deliberately not reset; count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/imem_prefetch.sv
// Sequential instruction prefetcher: streams words ahead of the core, redirects on branches.
module imem_prefetch
    import imem_prefetch_pkg::*;
#(
    parameter int              DEPTH       = 4,
    parameter logic [XLEN-1:0] REGION_BASE = 32'h0000_0000,
    parameter logic [XLEN:0]   REGION_SIZE = 33'd4096
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cpu_re_i,
    input  logic [XLEN-1:0] cpu_add_i,
    output logic [XLEN-1:0] cpu_data_o,
    output logic            cpu_valid_o,
    output logic            mem_re_o,
    output logic [XLEN-1:0] mem_add_o,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            mem_valid_i
);

    localparam int CW = $clog2(DEPTH) + 1;

    pf_state_e       state, state_next;
    logic [XLEN-1:0] next_add, next_add_nx;
    logic [XLEN-1:0] target, target_nx;
    logic            mem_re_nx;
    logic [XLEN-1:0] mem_add_nx;

    pf_entry_t       head;
    logic [CW-1:0]   count;
    logic [CW-1:0]   occupancy;
    logic [XLEN-1:0] expected;
    logic            hit, miss, push, flush, slot_free, demand;

    pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk_i),
        .rst        (rst_i),
        .push       (push),
        .pop        (hit),
        .flush      (flush),
        .push_entry ({mem_add_o, mem_data_i}),
        .head       (head),
        .count      (count)
    );

    assign expected  = (count != '0) ? head.tag : (mem_re_o ? mem_add_o : next_add);
    assign hit       = cpu_re_i && (count != '0) && (head.tag == cpu_add_i);
    assign miss      = cpu_re_i && (cpu_add_i != expected);
    assign slot_free = !mem_re_o || mem_valid_i;
    // Words already owned (buffered or in flight) once this cycle's pop retires.
    assign occupancy = count + CW'(mem_re_o) - CW'(hit);
    // Empty buffer, nothing in flight: the core's own address is fetched even outside the region.
    assign demand    = cpu_re_i && (count == '0) && !mem_re_o;

    assign cpu_valid_o = hit;
    assign cpu_data_o  = hit ? head.data : '0;

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next  = state;
        next_add_nx = next_add;
        target_nx   = target;
        mem_re_nx   = mem_re_o && !mem_valid_i;
        mem_add_nx  = mem_add_o;
        push        = 1'b0;
        flush       = 1'b0;
        unique case (state)
            IDLE: begin
                if (cpu_re_i) begin
                    mem_re_nx   = 1'b1;
                    mem_add_nx  = cpu_add_i;
                    next_add_nx = cpu_add_i + WORD_BYTES;
                    state_next  = RUN;
                end
            end
            RUN: begin
                if (miss) begin
                    flush = 1'b1;
                    if (slot_free) begin
                        mem_re_nx   = 1'b1;
                        mem_add_nx  = cpu_add_i;
                        next_add_nx = cpu_add_i + WORD_BYTES;
                    end else begin
                        target_nx  = cpu_add_i;
                        state_next = DRAIN;
                    end
                end else begin
                    push = mem_valid_i;
                    if (slot_free && (demand || ((occupancy < CW'(DEPTH)) &&
                        in_region(next_add, REGION_BASE, REGION_SIZE)))) begin
                        mem_re_nx   = 1'b1;
                        mem_add_nx  = next_add;
                        next_add_nx = next_add + WORD_BYTES;
                    end
                end
            end
            DRAIN: begin
                if (mem_valid_i) begin
                    mem_re_nx   = 1'b1;
                    mem_add_nx  = target;
                    next_add_nx = target + WORD_BYTES;
                    state_next  = RUN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            next_add  <= '0;
            target    <= '0;
            mem_re_o  <= 1'b0;
            mem_add_o <= '0;
        end else begin
            state     <= state_next;
            next_add  <= next_add_nx;
            target    <= target_nx;
            mem_re_o  <= mem_re_nx;
            mem_add_o <= mem_add_nx;
        end
    end

endmodule

// File: doc/imem_prefetch.md
# imem_prefetch

Sequential instruction prefetch buffer between the RV32i core's instruction port and the wait-state instruction memory (`wsync_mem`). While the core is executing, it fetches ahead of the core's fetch address into a small FIFO. Sequential fetches then hit at one word per cycle instead of paying the memory wait states. A non-sequential fetch (branch or jump) flushes the buffer and restarts the stream at the new address.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `REGION_BASE`, 32'h0000_0000: first byte address prefetch may issue to.
- `REGION_SIZE`, 4096: region size in bytes; no prefetch is issued at or beyond `REGION_BASE+REGION_SIZE`.
- `clk_i` in 1: single clock, rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `cpu_re_i` in 1: core fetch request; held with `cpu_add_i` stable until `cpu_valid_o`.
- `cpu_add_i` in 32: core fetch byte address (word aligned).
- `cpu_data_o` out 32: instruction word; meaningful when `cpu_valid_o`.
- `cpu_valid_o` out 1: fetch complete this cycle.
- `mem_re_o` out 1: memory read request (registered).
- `mem_add_o` out 32: memory byte address (registered).
- `mem_data_i` in 32: memory read data.
- `mem_valid_i` in 1: memory data valid; single-cycle pulse.

## Operation
- Reset values: `mem_re_o`=0, `mem_add_o`=0, `cpu_valid_o`=0, `cpu_data_o`=0. State is IDLE, FIFO count is 0, no request in flight.
- At most one memory request is outstanding. `mem_re_o`/`mem_add_o` stay stable until `mem_valid_i` is sampled high.
- FIFO entries hold {tag, data}; the tag is the word's byte address.
- The expected address E is selected in priority order:
  - head tag, if count>0;
  - otherwise the in-flight address, if a request is outstanding;
  - otherwise `next_add`.
- Hit: `cpu_re_i` && count>0 && head tag == `cpu_add_i`. In that case `cpu_valid_o`=1 combinationally, `cpu_data_o` = head data, and the head pops at the edge.
- Miss: `cpu_re_i` && `cpu_add_i` != E.
- States:
  - **IDLE**: no stream.
    - On `cpu_re_i`: set `next_add=cpu_add_i` and go to RUN.
  - **RUN**: issue a request at `next_add` when count + in-flight < `DEPTH` and `next_add` is in the region; then `next_add += 4`.
    - On a miss with no request in flight: flush the FIFO, set `next_add=cpu_add_i`, stay in RUN.
    - On a miss with a request in flight: flush the FIFO, capture the target, go to DRAIN.
  - **DRAIN**: the returning in-flight data is discarded. When `mem_valid_i` is sampled, set `next_add` to the target and go to RUN.
- A demand address outside the region is still fetched, as the first request after redirect. Only speculative prefetch is region-limited.
- Arithmetic: `next_add` is 32-bit modulo 2^32. The in-region test is `REGION_BASE <= a < REGION_BASE+REGION_SIZE` on 33-bit values, so there is no wrap false-positive.
- Simultaneous events:
  - Push and pop in the same cycle leave count unchanged.
  - A miss in the same cycle as `mem_valid_i`: that data is dropped, DRAIN is skipped, and the new request is issued next cycle.
  - A full FIFO never overflows, because space is reserved at issue.
- Reset mid-request: all state clears at once. The system resets `wsync_mem` with the same reset, so no stale `mem_valid_i` is produced.

## Timing
- W = memory cycles from `mem_re_o` first high to `mem_valid_i`.
- Cold or redirected fetch:
  - `cpu_re_i` at cycle 0;
  - `mem_re_o` high at cycle 1;
  - `mem_valid_i` at cycle W+1, with data written at that edge;
  - `cpu_valid_o` at cycle W+2.
- Redirect with a request in flight: add the remaining cycles of the stale request.
- Back-to-back requests: the next `mem_re_o`/`mem_add_o` values load at the same edge that samples `mem_valid_i`, so there are no idle cycles between requests.
- Streaming: one hit per cycle while count>0.
- No bypass: data returning from memory is never forwarded to the core in the same cycle.

## Structure
- `imem_prefetch_pkg`:
  - state enum `pf_state_e` {IDLE, RUN, DRAIN};
  - `XLEN`=32;
  - the FIFO entry struct `pf_entry_t` {tag, data}.
- Sub-module `pf_fifo`: synchronous FIFO of `pf_entry_t` with a flush input, count output, and combinational head. Pointers wrap at `DEPTH`.

## Test plan
Memory model has W=3 and holds `mem[i]` = 32'hA000_0000+i.
- **Cold start**: reset, then `cpu_re_i` with address 0x0 → `cpu_valid_o` exactly 5 cycles later with data A000_0000; `mem_add_o` steps through 0x4, 0x8, 0xC.
- **Stream**: after the FIFO fills, request 0x4, 0x8, 0xC on consecutive cycles → three consecutive `cpu_valid_o` cycles with data A000_0001..3; the FIFO never exceeds 4 entries.
- **Branch during in-flight request**: request 0x40 while 0x10 is outstanding → the 0x10 data is dropped and `mem_add_o`=0x40 issues the cycle after 0x10's valid; the core receives A000_0010.
- **Miss coincident with `mem_valid_i`**: no DRAIN; the new address issues the next cycle.
- **Region end**: stream to 0xFFC → no `mem_re_o` at 0x1000; a demand fetch to 0x1000 still issues.
- **Reset mid-request**: assert `rst_i` while `mem_re_o`=1 → all outputs are 0 asynchronously; after release, fetch 0x8 returns A000_0002 correctly.
